// File: rtl/irq_ctrl_mc.sv
// irq_ctrl_mc: multi-channel interrupt controller with per-channel edge/level
// sensitivity, per-channel mask and fixed lowest-index-wins priority. It
// presents one request/code pair to the core over a req/ack handshake.
// Optional build macro: IRQ_CTRL_MC_SYNC_EN adds a 2-flop input synchroniser
// on irq_i. This allows asynchronous sources and adds 2 cycles of latency.
module irq_ctrl_mc #(
  parameter int N_CH      = 8,
  parameter int CODE_W    = 8,
  parameter int CODE_BASE = 3
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [N_CH-1:0]   irq_i,
  input  logic [N_CH-1:0]   edge_mode_i,
  input  logic [N_CH-1:0]   mask_i,
  output logic              irq_req_o,
  output logic [CODE_W-1:0] irq_code_bo,
  input  logic              irq_ack_i,
  output logic [N_CH-1:0]   pending_bo
);

  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  // The highest code presented must fit in irq_code_bo.
  if ((64'(CODE_BASE) + 64'(N_CH) - 64'd1) >= (64'd1 << CODE_W)) begin : g_code_range_bad
    $error("irq_ctrl_mc: CODE_BASE+N_CH-1 does not fit in CODE_W bits");
  end

  typedef enum logic {IDLE, REQ} state_t;

  state_t            state_reg, state_next;
  logic [SEL_W-1:0]  sel_reg, sel_next;
  logic [CODE_W-1:0] code_reg, code_next;
  logic [N_CH-1:0]   buf_reg;
  logic [N_CH-1:0]   pend_edge_reg, pend_edge_next;
  logic [N_CH-1:0]   irq_s;
  logic [N_CH-1:0]   posedge_vec;
  logic [N_CH-1:0]   clr_vec;
  logic [N_CH-1:0]   eligible;
  logic [SEL_W-1:0]  win_idx;

`ifdef IRQ_CTRL_MC_SYNC_EN
  logic [N_CH-1:0] sync1_reg, sync2_reg;

  // Two-flop synchroniser bringing asynchronous lines into the clk_i domain.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= irq_i;
      sync2_reg <= sync1_reg;
    end
  end

  assign irq_s = sync2_reg;
`else
  assign irq_s = irq_i;
`endif

  // Per-channel edge detect, ack clear and pending view.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    assign posedge_vec[gi] = ~buf_reg[gi] & irq_s[gi];
    // Only the channel being served, and only when it is edge mode, is cleared.
    assign clr_vec[gi] = (state_reg == REQ) && irq_ack_i &&
                         (sel_reg == SEL_W'(gi)) && edge_mode_i[gi];
    // A new edge wins over a simultaneous clear so it is not lost.
    assign pend_edge_next[gi] = (pend_edge_reg[gi] & ~clr_vec[gi]) |
                                (posedge_vec[gi] & edge_mode_i[gi]);
    assign pending_bo[gi] = edge_mode_i[gi] ? pend_edge_reg[gi] : irq_s[gi];
  end

  assign eligible = pending_bo & mask_i;

  // Fixed priority: lowest eligible index wins (scan downward so it ends on the lowest).
  always_comb begin
    win_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (eligible[i]) win_idx = SEL_W'(i);
    end
  end

  // Edge buffers and stored edge pending bits.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      buf_reg       <= '0;
      pend_edge_reg <= '0;
    end else begin
      buf_reg       <= irq_s;
      pend_edge_reg <= pend_edge_next;
    end
  end

  // Handshake FSM state, selected channel and presented code.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg <= IDLE;
      sel_reg   <= '0;
      code_reg  <= '0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      code_reg  <= code_next;
    end
  end

  // Next-state logic: latch the winner from IDLE, hold it in REQ until ack.
  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    code_next  = code_reg;
    case (state_reg)
      IDLE: begin
        if (eligible != '0) begin
          state_next = REQ;
          sel_next   = win_idx;
          code_next  = CODE_W'(CODE_BASE) + CODE_W'(win_idx);
        end
      end
      REQ: begin
        if (irq_ack_i) begin
          state_next = IDLE;
          code_next  = '0;
        end
      end
      default: begin
        state_next = IDLE;
        code_next  = '0;
      end
    endcase
  end

  assign irq_req_o   = (state_reg == REQ);
  assign irq_code_bo = code_reg;

endmodule

// File: tb/tb_irq_ctrl_mc.sv
// Directed self-checking bench for irq_ctrl_mc (N_CH=8, CODE_BASE=3, no sync).
module tb_irq_ctrl_mc;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic [7:0] irq_i;
  logic [7:0] edge_mode_i;
  logic [7:0] mask_i;
  logic       irq_req_o;
  logic [7:0] irq_code_bo;
  logic       irq_ack_i;
  logic [7:0] pending_bo;

  int checks   = 0;
  int failures = 0;

  irq_ctrl_mc #(.N_CH(8), .CODE_W(8), .CODE_BASE(3)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .irq_i       (irq_i),
    .edge_mode_i (edge_mode_i),
    .mask_i      (mask_i),
    .irq_req_o   (irq_req_o),
    .irq_code_bo (irq_code_bo),
    .irq_ack_i   (irq_ack_i),
    .pending_bo  (pending_bo)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic req, input logic [7:0] code);
    chk({tag, "_req"}, {31'd0, irq_req_o}, {31'd0, req});
    chk({tag, "_code"}, {24'd0, irq_code_bo}, {24'd0, code});
    $display("t=%0t %s req=%0b code=%02h pend=%02h", $time, tag, irq_req_o, irq_code_bo, pending_bo);
  endtask

  // Pulse ack across exactly one rising edge.
  task automatic ack_once();
    irq_ack_i = 1'b1;
    step();
    irq_ack_i = 1'b0;
  endtask

  initial begin
    rst_n_i     = 1'b0;
    irq_i       = 8'h00;
    edge_mode_i = 8'hFF;
    mask_i      = 8'hFF;
    irq_ack_i   = 1'b0;
    step();
    step();
    chk_out("reset", 1'b0, 8'h00);
    chk("reset_pend", {24'd0, pending_bo}, 32'h00);
    rst_n_i = 1'b1;
    step();

    // Single edge pulse on channel 0: pending after edge k, request after k+1.
    irq_i = 8'h01;
    step();
    irq_i = 8'h00;
    chk_out("ch0_k", 1'b0, 8'h00);
    chk("ch0_pend", {24'd0, pending_bo}, 32'h01);
    step();
    chk_out("ch0_k1", 1'b1, 8'h03);
    step();
    step();
    chk_out("ch0_hold", 1'b1, 8'h03);
    ack_once();
    chk_out("ch0_ack", 1'b0, 8'h00);
    chk("ch0_pend_clr", {24'd0, pending_bo}, 32'h00);
    step();
    chk_out("ch0_idle", 1'b0, 8'h00);

    // Simultaneous edges on channels 5 and 2: channel 2 first.
    irq_i = 8'h24;
    step();
    irq_i = 8'h00;
    chk("ch52_pend", {24'd0, pending_bo}, 32'h24);
    step();
    chk_out("ch2_req", 1'b1, 8'h05);
    ack_once();
    chk_out("ch2_ack", 1'b0, 8'h00);
    chk("ch5_pend", {24'd0, pending_bo}, 32'h20);
    step();
    chk_out("ch5_req", 1'b1, 8'h08);
    ack_once();
    chk_out("ch5_ack", 1'b0, 8'h00);
    step();
    chk_out("ch5_idle", 1'b0, 8'h00);
    chk("ch5_pend_clr", {24'd0, pending_bo}, 32'h00);

    // Level channel 4 held high: re-requested after each ack with one idle cycle.
    edge_mode_i = 8'hEF;
    irq_i = 8'h10;
    step();
    chk_out("lvl_req0", 1'b1, 8'h07);
    for (int n = 0; n < 3; n++) begin
      ack_once();
      chk_out("lvl_ack", 1'b0, 8'h00);
      step();
      chk_out("lvl_rereq", 1'b1, 8'h07);
    end
    irq_i = 8'h00;
    ack_once();
    chk_out("lvl_drop_ack", 1'b0, 8'h00);
    step();
    step();
    chk_out("lvl_dropped", 1'b0, 8'h00);
    edge_mode_i = 8'hFF;
    chk("lvl_pend", {24'd0, pending_bo}, 32'h00);

    // Masked edge on channel 1 stays pending; unmasking raises the request.
    mask_i = 8'hFD;
    irq_i  = 8'h02;
    step();
    irq_i = 8'h00;
    chk("mask_pend", {24'd0, pending_bo}, 32'h02);
    step();
    chk_out("masked", 1'b0, 8'h00);
    mask_i = 8'hFF;
    step();
    chk_out("unmasked", 1'b1, 8'h04);
    ack_once();
    chk_out("unmask_ack", 1'b0, 8'h00);

    // Channel 3 edge coincident with its own ack: set wins, served again.
    irq_i = 8'h08;
    step();
    irq_i = 8'h00;
    step();
    chk_out("ch3_req", 1'b1, 8'h06);
    irq_i     = 8'h08;
    irq_ack_i = 1'b1;
    step();
    irq_i     = 8'h00;
    irq_ack_i = 1'b0;
    chk_out("ch3_ack", 1'b0, 8'h00);
    chk("ch3_pend_kept", {24'd0, pending_bo}, 32'h08);
    step();
    chk_out("ch3_rereq", 1'b1, 8'h06);
    ack_once();
    chk_out("ch3_done", 1'b0, 8'h00);

    // Ack while idle is ignored.
    ack_once();
    chk_out("idle_ack", 1'b0, 8'h00);
    chk("idle_ack_pend", {24'd0, pending_bo}, 32'h00);
    step();
    chk_out("idle_ack2", 1'b0, 8'h00);

    // Reset asserted mid-REQ clears outputs without a clock edge.
    irq_i = 8'h01;
    step();
    irq_i = 8'h00;
    step();
    chk_out("pre_rst", 1'b1, 8'h03);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 8'h00);
    chk("async_rst_pend", {24'd0, pending_bo}, 32'h00);
    step();
    rst_n_i = 1'b1;
    step();
    chk_out("post_rst", 1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_ctrl_mc.md
Name: irq_ctrl_mc

Overview:
- Multi-channel successor to the single-line IRQ adapter.
- Takes N_CH debounced interrupt lines. Each line is per-channel selectable as edge or level sensitive, and each has a mask bit.
- Pending channels are arbitrated by fixed priority. The winner is presented to the core as one request/code pair over the same req/ack handshake.
- Sits between the debouncers and the sigma_tile CPU interrupt interface.

Parameters:
- N_CH, 8, number of interrupt channels (1..32).
- CODE_W, 8, width of irq_code_bo.
- CODE_BASE, 3, code presented for channel 0; channel i presents CODE_BASE+i. Requirement: CODE_BASE+N_CH-1 < 2^CODE_W (checked by elaboration-time assertion).

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- irq_i  in  N_CH  debounced interrupt lines, bit i = channel i.
- edge_mode_i  in  N_CH  1 = channel edge sensitive (rising), 0 = level sensitive (high).
- mask_i  in  N_CH  1 = channel enabled for arbitration.
- irq_req_o  out  1  interrupt request to core.
- irq_code_bo  out  CODE_W  code of the presented channel; 0 when no request.
- irq_ack_i  in  1  core acknowledge.
- pending_bo  out  N_CH  pending vector, for debug/CSR readback.

Behaviour:
- Reset (async assert, sync release): irq_req_o=0, irq_code_bo=0, edge buffers=0, edge pending=0, FSM=IDLE.
- Edge buffer reset is 0, so a line already high at reset release counts as a rising edge on the first clock.
- Edge channel i:
  - irq_posedge_i = !buf_i & irq_i.
  - pend_edge_i is set on a posedge.
  - pend_edge_i is cleared only by an ack of channel i.
  - Set wins over a simultaneous clear.
- Level channel i: effective pending = irq_i (live). Not stored, so ack has no effect.
- pending_bo[i] = edge_mode_i ? pend_edge_i : irq_i.
- Masking:
  - eligible = pending_bo & mask_i.
  - Masking does not clear edge pending; unmasking later raises the request.
- Priority: fixed; lowest eligible index wins.
- FSM has two states:
  - IDLE:
    - irq_req_o=0.
    - If eligible != 0 at a rising edge: latch winner index into sel, set irq_req_o=1 and irq_code_bo=CODE_BASE+sel, go REQ.
  - REQ:
    - irq_req_o and irq_code_bo held stable regardless of irq_i or mask_i changes; no withdrawal.
    - On irq_ack_i=1: clear pend_edge[sel] (if channel sel is edge mode), set irq_req_o=0 and irq_code_bo=0, go IDLE.
- irq_ack_i while in IDLE is ignored.
- Minimum one cycle with irq_req_o=0 between consecutive requests.
- Latency:
  - Edge channel: line high at edge k (buf low) -> pending after edge k -> irq_req_o=1 after edge k+1.
  - Level channel: line high at edge k -> irq_req_o=1 after edge k.
- Level channel still high after its ack is re-requested from IDLE on the next edge.
- Edge on a channel while it is being served:
  - Before the ack edge: sets pending again; served again after ack.
  - Same cycle as ack: set wins; served again.
- Channel with mode change while pending: pending_bo follows the new mode immediately; stored edge pending bit is kept.
- Reset asserted mid-handshake: all state cleared immediately; the core must drop any in-flight ack.

Optional Feature:
- Macro: IRQ_CTRL_MC_SYNC_EN.
- Defined:
  - irq_i passes a 2-flop synchroniser (reset 0) before edge detection and level use.
  - All latencies above increase by 2 cycles.
  - Allows asynchronous sources.
- Undefined: irq_i is used directly and must be synchronous to clk_i.

Test Plan (feature undefined, CODE_BASE=3, N_CH=8):
- Reset, then pulse irq_i[0] high 1 cycle, edge mode, mask=FF -> irq_req_o=1 two edges later with irq_code_bo=03. Hold until ack; after ack, req=0 and code=00; pending_bo=00.
- Rising edges on channels 5 and 2 in the same cycle -> code 05 presented first (channel 2). Ack -> one idle cycle -> code 08 (channel 5). Ack -> idle.
- Channel 4 in level mode held high across 3 acks -> code 07 re-presented after each ack with exactly one idle cycle between. Drop the line -> no further request.
- Edge on channel 1 with mask[1]=0 -> pending_bo[1]=1, no request. Set mask[1]=1 -> request with code 04 after next edge.
- Channel 3 edge coincident with its own ack -> request with code 06 reappears after the idle cycle.
- Ack pulsed while IDLE -> no state change. Assert rst_n_i low mid-REQ -> irq_req_o=0 and code=00 without waiting for a clock edge.
